// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, ROM addressing, jump/halt pre-decode, registered issue to decode.
// Latency: ROM word at pc in cycle N is presented on instr in cycle N+1; redirect in N fetches in N+1.
// Backpressure: instr/instr_pc hold while instr_valid & !instr_ready; optional FETCH_JUMP_PREDECODE_EN.
module fetch_unit #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 10,
    parameter logic [DATA_W-1:0] HALT_WORD = 10'b0010000010,
    parameter logic [3:0]        JUMP_OP   = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

`ifdef FETCH_JUMP_PREDECODE_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              vld_q, vld_d;
    logic              halted_q, halted_d;

    logic              transfer;
    logic              out_free;
    logic              is_halt;
    logic              is_jump;
    logic [ADDR_W-1:0] jump_target;

    assign transfer    = vld_q & instr_ready;
    assign out_free    = ~vld_q | transfer;
    assign is_halt     = (rom_data == HALT_WORD);
    assign is_jump     = JUMP_EN && (rom_data[DATA_W-1 -: 4] == JUMP_OP);
    assign jump_target = ADDR_W'(rom_data[5:0]);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ipc_d    = ipc_q;
        instr_d  = instr_q;
        vld_d    = vld_q;
        halted_d = halted_q;
        if (redirect) begin
            // Flush wins over any pending hand-off; the target is fetched next cycle.
            pc_d     = redirect_pc;
            vld_d    = 1'b0;
            halted_d = 1'b0;
            state_d  = RUN;
        end else begin
            case (state_q)
                RUN, HOLD: begin
                    if (!out_free) begin
                        state_d = HOLD;
                    end else if (is_halt) begin
                        instr_d  = rom_data;
                        ipc_d    = pc_q;
                        vld_d    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else if (is_jump) begin
                        // Jump is consumed here; the slot it would have used becomes a bubble.
                        pc_d    = jump_target;
                        vld_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        instr_d = rom_data;
                        ipc_d   = pc_q;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = RUN;
                    end
                end
                HALT: begin
                    if (transfer) vld_d = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= '0;
            ipc_q    <= '0;
            instr_q  <= '0;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ipc_q    <= ipc_d;
            instr_q  <= instr_d;
            vld_q    <= vld_d;
            halted_q <= halted_d;
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = vld_q;
    assign halted      = halted_q;

endmodule
